// File: rtl/uart_encoder_if.sv
// UART response encoder handshake bundle.
// Upstream word strobe plus byte stream toward the UART transmitter.
interface uart_encoder_if;
  logic        i_stb;
  logic [33:0] i_word;
  logic        o_busy;
  logic        o_tx_stb;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;

  modport master (
    output i_stb,
    output i_word,
    output i_tx_busy,
    input  o_busy,
    input  o_tx_stb,
    input  o_tx_data
  );

  modport slave (
    input  i_stb,
    input  i_word,
    input  i_tx_busy,
    output o_busy,
    output o_tx_stb,
    output o_tx_data
  );
endinterface

// File: rtl/uart_encoder.sv
// UART response encoder: {cmd,data} word -> letter, hex digits, 'E', LF.
// Bytes are registered and held until the transmitter takes them.
module uart_encoder #(
  parameter bit SKIP_ZEROS = 1'b0,
  parameter bit EMIT_NL    = 1'b1
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_HEX,
    S_END,
    S_NL
  } state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic [2:0]  r_idx;
  logic        r_tx_stb;
  logic [7:0]  r_tx_data;

  logic        w_xfer;
  logic [2:0]  w_msd;
  logic [2:0]  w_start;
  logic [2:0]  w_idx_dn;
  logic [3:0]  w_start_nib;
  logic [3:0]  w_dn_nib;

  function automatic logic [7:0] cmd_char(input logic [1:0] c);
    logic [7:0] ch;
    unique case (c)
      2'b00:   ch = 8'h52;
      2'b01:   ch = 8'h57;
      2'b10:   ch = 8'h41;
      default: ch = 8'h53;
    endcase
    return ch;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  assign w_xfer      = r_tx_stb && !bus.i_tx_busy;
  assign w_idx_dn    = r_idx - 3'd1;
  assign w_start     = SKIP_ZEROS ? w_msd : 3'd7;
  assign w_start_nib = r_data[{w_start, 2'b00} +: 4];
  assign w_dn_nib    = r_data[{w_idx_dn, 2'b00} +: 4];

  // Highest non-zero nibble of the latched data, 0 when data is zero.
  always_comb begin
    w_msd = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (r_data[4*k +: 4] != 4'h0)
        w_msd = 3'(k);
    end
  end

  // Frame sequencer; each byte is loaded one cycle ahead of its slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_idx     <= '0;
      r_tx_stb  <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_stb) begin
            r_state   <= S_CMD;
            r_data    <= bus.i_word[31:0];
            r_tx_stb  <= 1'b1;
            r_tx_data <= cmd_char(bus.i_word[33:32]);
          end
        end
        S_CMD: begin
          if (w_xfer) begin
            r_state   <= S_HEX;
            r_idx     <= w_start;
            r_tx_data <= hex_char(w_start_nib);
          end
        end
        S_HEX: begin
          if (w_xfer) begin
            if (r_idx == 3'd0) begin
              r_state   <= S_END;
              r_tx_data <= 8'h45;
            end else begin
              r_idx     <= w_idx_dn;
              r_tx_data <= hex_char(w_dn_nib);
            end
          end
        end
        S_END: begin
          if (w_xfer) begin
            if (EMIT_NL) begin
              r_state   <= S_NL;
              r_tx_data <= 8'h0A;
            end else begin
              r_state   <= S_IDLE;
              r_tx_stb  <= 1'b0;
              r_tx_data <= 8'h00;
            end
          end
        end
        S_NL: begin
          if (w_xfer) begin
            r_state   <= S_IDLE;
            r_tx_stb  <= 1'b0;
            r_tx_data <= 8'h00;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tx_stb <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_tx_stb  = r_tx_stb;
  assign bus.o_tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_encoder.sv
// Bench for uart_encoder: three parameter variants, queue scoreboard,
// frame model built from the byte-format rules.
module tb_uart_encoder;

  localparam bit [2:0] SKP = 3'b010;
  localparam bit [2:0] ENL = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb [3] = '{1'b0, 1'b0, 1'b0};
  logic        txb [3] = '{1'b0, 1'b0, 1'b0};
  logic [33:0] word = '0;
  int          bp_mode [3] = '{0, 0, 0};

  logic        ostb  [3];
  logic        obusy [3];
  logic [7:0]  odat  [3];

  logic [8:0]  expq [3][$];

  int total = 0;
  int bad = 0;

  uart_encoder_if bus0 ();
  uart_encoder_if bus1 ();
  uart_encoder_if bus2 ();

  assign bus0.i_stb = stb[0];
  assign bus1.i_stb = stb[1];
  assign bus2.i_stb = stb[2];
  assign bus0.i_word = word;
  assign bus1.i_word = word;
  assign bus2.i_word = word;
  assign bus0.i_tx_busy = txb[0];
  assign bus1.i_tx_busy = txb[1];
  assign bus2.i_tx_busy = txb[2];
  assign ostb[0] = bus0.o_tx_stb;
  assign ostb[1] = bus1.o_tx_stb;
  assign ostb[2] = bus2.o_tx_stb;
  assign obusy[0] = bus0.o_busy;
  assign obusy[1] = bus1.o_busy;
  assign obusy[2] = bus2.o_busy;
  assign odat[0] = bus0.o_tx_data;
  assign odat[1] = bus1.o_tx_data;
  assign odat[2] = bus2.o_tx_data;

  uart_encoder #(.SKIP_ZEROS(SKP[0]), .EMIT_NL(ENL[0])) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0.slave));
  uart_encoder #(.SKIP_ZEROS(SKP[1]), .EMIT_NL(ENL[1])) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1.slave));
  uart_encoder #(.SKIP_ZEROS(SKP[2]), .EMIT_NL(ENL[2])) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, d, got, want, $time);
    end
  endtask

  // Reference: ASCII frame from the word, as a list of {last, byte}.
  task automatic push_frame(input int d, input logic [1:0] cmd,
                            input logic [31:0] data);
    string letters;
    int nd;
    int nib;
    letters = "RWAS";
    expq[d].push_back({1'b0, letters[cmd]});
    nd = 8;
    if (SKP[d]) begin
      while (nd > 1 && ((data >> (4 * (nd - 1))) & 32'hf) == 0)
        nd--;
    end
    for (int k = nd - 1; k >= 0; k--) begin
      nib = int'((data >> (4 * k)) & 32'hf);
      if (nib < 10)
        expq[d].push_back({1'b0, 8'(8'h30 + nib)});
      else
        expq[d].push_back({1'b0, 8'(8'h61 + nib - 10)});
    end
    expq[d].push_back({!ENL[d], 8'h45});
    if (ENL[d])
      expq[d].push_back({1'b1, 8'h0A});
  endtask

  // Transmitter backpressure: 0 ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      case (bp_mode[i])
        0:       txb[i] = 1'b0;
        1:       txb[i] = ($urandom_range(0, 2) == 0);
        default: txb[i] = 1'b1;
      endcase
    end
  end

  logic       m_stall [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] m_sdat  [3];
  logic       m_more  [3] = '{1'b0, 1'b0, 1'b0};
  logic       m_last  [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] m_e;

  // Monitor: pops on every byte transfer, checks hold and no-bubble rules.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_stall[i] = 1'b0;
        m_more[i]  = 1'b0;
        m_last[i]  = 1'b0;
      end else begin
        if (m_stall[i]) begin
          chk("hold_stb", i, 32'(ostb[i]), 32'd1);
          chk("hold_data", i, 32'(odat[i]), 32'(m_sdat[i]));
        end
        if (m_more[i])
          chk("no_bubble", i, 32'(ostb[i]), 32'd1);
        if (m_last[i]) begin
          chk("busy_drop", i, 32'(obusy[i]), 32'd0);
          chk("idle_stb", i, 32'(ostb[i]), 32'd0);
        end
        m_more[i]  = 1'b0;
        m_last[i]  = 1'b0;
        m_stall[i] = ostb[i] && txb[i];
        m_sdat[i]  = odat[i];
        if (ostb[i] && !txb[i]) begin
          if (expq[i].size() == 0) begin
            chk("extra_byte", i, 32'(odat[i]), 32'hffff_ffff);
          end else begin
            m_e = expq[i].pop_front();
            chk("byte", i, 32'(odat[i]), 32'(m_e[7:0]));
            if (m_e[8])
              m_last[i] = 1'b1;
            else
              m_more[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (expq[d].size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("timeout", d, 32'(expq[d].size()), 32'd0);
      expq[d].delete();
    end
  endtask

  task automatic junk_word();
    word[31:0]  = $urandom;
    word[33:32] = 2'($urandom_range(0, 3));
  endtask

  // One-cycle strobe; accept edge is the posedge right before return.
  task automatic issue(input int d, input logic [1:0] cmd,
                       input logic [31:0] data);
    @(posedge clk);
    #1;
    stb[d] = 1'b1;
    word = {cmd, data};
    push_frame(d, cmd, data);
    @(posedge clk);
    #1;
    stb[d] = 1'b0;
    junk_word();
  endtask

  logic [31:0] rd;
  int n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_stb", i, 32'(ostb[i]), 32'd0);
      chk("rst_busy", i, 32'(obusy[i]), 32'd0);
      chk("rst_data", i, 32'(odat[i]), 32'h00);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame, first byte on the cycle after accept.
    issue(0, 2'b01, 32'h0000_00a5);
    @(negedge clk);
    chk("lat_stb", 0, 32'(ostb[0]), 32'd1);
    chk("lat_data", 0, 32'(odat[0]), 32'h57);
    wait_idle(0);

    // Leading-zero suppression.
    issue(1, 2'b10, 32'h0);
    wait_idle(1);
    issue(1, 2'b00, 32'h00f0_1234);
    wait_idle(1);

    // Five-cycle stall on the third byte.
    issue(0, 2'b01, 32'h0000_00a5);
    @(posedge clk);
    @(posedge clk);
    #1;
    bp_mode[0] = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_stb", 0, 32'(ostb[0]), 32'd1);
      chk("stall_data", 0, 32'(odat[0]), 32'h30);
    end
    @(posedge clk);
    #1;
    bp_mode[0] = 0;
    wait_idle(0);

    // Strobe while busy must be dropped.
    issue(0, 2'b01, 32'h0000_00a5);
    repeat (3) @(posedge clk);
    #1;
    stb[0] = 1'b1;
    word = {2'b11, 32'hdead_beef};
    @(posedge clk);
    #1;
    stb[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_s_frame", 0, 32'(ostb[0]), 32'd0);

    // Reset in the middle of the hex digits.
    issue(0, 2'b01, 32'h1234_5678);
    n = 0;
    while (expq[0].size() > 6 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      expq[i].delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("abort_stb", i, 32'(ostb[i]), 32'd0);
      chk("abort_busy", i, 32'(obusy[i]), 32'd0);
    end
    issue(0, 2'b01, 32'h1234_5678);
    wait_idle(0);

    // Back-to-back strobes, no line feed.
    @(posedge clk);
    #1;
    stb[2] = 1'b1;
    word = {2'b00, 32'h1};
    push_frame(2, 2'b00, 32'h1);
    push_frame(2, 2'b01, 32'h2);
    @(posedge clk);
    #1;
    word = {2'b01, 32'h2};
    n = 0;
    while (expq[2].size() != 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    stb[2] = 1'b0;
    @(negedge clk);
    chk("b2b_stb", 2, 32'(ostb[2]), 32'd1);
    chk("b2b_data", 2, 32'(odat[2]), 32'h57);
    wait_idle(2);

    // Random words under random backpressure on every variant.
    for (int d = 0; d < 3; d++) begin
      bp_mode[d] = 1;
      for (int k = 0; k < 25; k++) begin
        wait_idle(d);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        rd = $urandom >> $urandom_range(0, 32);
        issue(d, 2'($urandom_range(0, 3)), rd);
      end
      wait_idle(d);
      bp_mode[d] = 0;
    end

    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++)
      chk("leftover", i, 32'(expq[i].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
